// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and the FIPS-197 forward/inverse S-box tables.
package aes_pkg;

   typedef logic [7:0]   byte_t;
   typedef logic [127:0] state_t;

   // Engine control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } eng_state_e;

   // Forward S-box, index 0 first
   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Inverse S-box, index 0 first
   localparam byte_t INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Forward or inverse byte substitution selected by inv
   function automatic byte_t sbox_f(input byte_t b, input logic inv);
      return inv ? INV_SBOX[b] : SBOX[b];
   endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational forward/inverse S-box lane.
module sbox_lane
   import aes_pkg::*;
(
   input  logic [7:0] b_in,
   input  logic       inv,
   output logic [7:0] b_out
);

   assign b_out = sbox_f(b_in, inv);

endmodule

// File: rtl/sub_bytes_engine.sv
// Time-multiplexed SubBytes/InvSubBytes engine: LANES S-boxes walk the 16 state
// bytes in 16/LANES cycles, with valid/ready handshakes on both sides.
module sub_bytes_engine
   import aes_pkg::*;
#(
   parameter int LANES = 16
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         inv_mode,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);

   localparam int N     = 16 / LANES;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES=%0d is illegal, use 1, 2, 4, 8 or 16", LANES);
   end

   eng_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   state_t           r_work;
   logic             r_inv;
   logic             r_out_valid;
   logic             r_busy;

   logic [4:0]       w_base;
   logic [4:0]       w_lane_idx [LANES];
   byte_t            w_lane_in  [LANES];
   byte_t            w_lane_out [LANES];
   state_t           w_work_next;

   // First byte of the group handled this cycle; unsigned 5-bit math, max 15
   assign w_base = 5'(r_cnt) * 5'(LANES);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_lane_idx[l] = w_base + 5'(l);
      assign w_lane_in[l]  = r_work[7'({w_lane_idx[l], 3'b000}) +: 8];

      sbox_lane u_lane (
         .b_in  (w_lane_in[l]),
         .inv   (r_inv),
         .b_out (w_lane_out[l])
      );
   end

   // Write the substituted group back in place, all other bytes pass through
   always_comb begin
      // NOTE: the full-width default before the partial writes keeps this purely
      // combinational; without it the untouched bytes would infer latches.
      w_work_next = r_work;
      for (int l = 0; l < LANES; l++) begin
         w_work_next[7'({w_lane_idx[l], 3'b000}) +: 8] = w_lane_out[l];
      end
   end

   // Control FSM with registered status outputs and the work register
   always_ff @(posedge clk) begin
      // NOTE: every state element, the 128-bit work register included, is cleared by
      // reset and updated with non-blocking assignments so all reads see pre-edge values.
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_work      <= '0;
         r_inv       <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_work  <= data_in;
                  r_inv   <= inv_mode;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_work <= w_work_next;
               if (r_cnt == CNT_LAST) begin
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign data_out  = r_work;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench: three engines (LANES 1, 4, 16) share one stimulus stream and are
// checked against hand-computed FIPS-197 vectors.
module tb_sub_bytes_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         inv_mode;
   logic         out_ready;
   logic [127:0] data_in;

   logic         ir   [3];
   logic         ov   [3];
   logic         bz   [3];
   logic [127:0] dout [3];

   localparam int LANES_T [3] = '{1, 4, 16};
   localparam int N_T     [3] = '{16, 4, 1};

   localparam logic [127:0] ALL_63  = {16{8'h63}};
   localparam logic [127:0] ALL_53  = {16{8'h53}};
   localparam logic [127:0] ALL_ED  = {16{8'hed}};
   localparam logic [127:0] T2_IN   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
   localparam logic [127:0] T2_OUT  = 128'h76abd7fe_2b670130_c56f6bf2_7b777c63;
   localparam logic [127:0] SGL_IN  = {{14{8'h63}}, 8'hed, 8'h63};
   localparam logic [127:0] SGL_OUT = {{14{8'h00}}, 8'h53, 8'h00};

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sub_bytes_engine #(.LANES(1)) u_dut_l1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .inv_mode(inv_mode),
      .data_in(data_in), .out_valid(ov[0]), .out_ready(out_ready), .data_out(dout[0]), .busy(bz[0])
   );
   sub_bytes_engine #(.LANES(4)) u_dut_l4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .inv_mode(inv_mode),
      .data_in(data_in), .out_valid(ov[1]), .out_ready(out_ready), .data_out(dout[1]), .busy(bz[1])
   );
   sub_bytes_engine #(.LANES(16)) u_dut_l16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .inv_mode(inv_mode),
      .data_in(data_in), .out_valid(ov[2]), .out_ready(out_ready), .data_out(dout[2]), .busy(bz[2])
   );

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic e_ir, input logic e_ov, input logic e_bz);
      for (int j = 0; j < 3; j++) begin
         check($sformatf("%s.in_ready[L%0d]", tag, LANES_T[j]), 128'(ir[j]), 128'(e_ir));
         check($sformatf("%s.out_valid[L%0d]", tag, LANES_T[j]), 128'(ov[j]), 128'(e_ov));
         check($sformatf("%s.busy[L%0d]", tag, LANES_T[j]), 128'(bz[j]), 128'(e_bz));
      end
   endtask

   task automatic check_data(input string tag, input logic [127:0] exp);
      for (int j = 0; j < 3; j++) begin
         check($sformatf("%s.data_out[L%0d]", tag, LANES_T[j]), dout[j], exp);
      end
   endtask

   // One-cycle request; returns just after the accepting edge
   task automatic start(input string tag, input logic [127:0] d, input logic inv);
      in_valid = 1'b1;
      data_in  = d;
      inv_mode = inv;
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         check($sformatf("%s.accept_busy[L%0d]", tag, LANES_T[j]), 128'(bz[j]), 128'(1'b1));
         check($sformatf("%s.accept_in_ready[L%0d]", tag, LANES_T[j]), 128'(ir[j]), 128'(1'b0));
      end
   endtask

   // 16 clocks after accept: out_valid must rise exactly N clocks in and then hold
   task automatic wait_latency(input string tag);
      for (int k = 1; k <= 16; k++) begin
         tick();
         for (int j = 0; j < 3; j++) begin
            check($sformatf("%s.lat%0d[L%0d]", tag, k, LANES_T[j]), 128'(ov[j]), 128'(k >= N_T[j]));
         end
      end
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_flags({tag, ".post_hs"}, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic run_txn(input string tag, input logic [127:0] d, input logic inv, input logic [127:0] exp);
      start(tag, d, inv);
      wait_latency(tag);
      check_data(tag, exp);
      handshake(tag);
   endtask

   // Hard bound on total run time
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      inv_mode  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check_flags("reset", 1'b1, 1'b0, 1'b0);
      check_data("reset", '0);
      tick();
      check_flags("idle", 1'b1, 1'b0, 1'b0);

      // 1: all-zero state -> all 63
      run_txn("fwd_zero", '0, 1'b0, ALL_63);

      // 2: bytes 00..0f forward
      run_txn("fwd_seq", T2_IN, 1'b0, T2_OUT);

      // 3: inverse round trip and single-byte inverse values
      run_txn("inv_seq", T2_OUT, 1'b1, T2_IN);
      run_txn("inv_single", SGL_IN, 1'b1, SGL_OUT);

      // 4: backpressure in DONE, second request pending meanwhile
      start("bp", T2_IN, 1'b0);
      wait_latency("bp");
      in_valid = 1'b1;
      data_in  = ALL_53;
      inv_mode = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_flags($sformatf("bp.hold%0d", c), 1'b0, 1'b1, 1'b1);
         check_data($sformatf("bp.hold%0d", c), T2_OUT);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_flags("bp.hs_no_accept", 1'b1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      check_flags("bp.second_accept", 1'b0, 1'b0, 1'b1);
      wait_latency("bp2");
      check_data("bp2", ALL_ED);
      handshake("bp2");

      // 5: inputs change right after accept; latched values must be used
      start("midchg", T2_IN, 1'b0);
      data_in  = '0;
      inv_mode = 1'b1;
      wait_latency("midchg");
      check_data("midchg", T2_OUT);
      handshake("midchg");

      // 6: reset with LANES 1/4 in BUSY at cnt=1 (LANES 16 already in DONE)
      start("rst_mid", ALL_63, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_flags("rst_mid", 1'b1, 1'b0, 1'b0);
      check_data("rst_mid", '0);
      run_txn("post_rst", ALL_ED, 1'b1, ALL_53);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
